// File: rtl/alu_ctrl_unit.sv
// -----------------------------------------------------------------------------
// alu_ctrl_unit
//
// Execute-stage block for the five-stage MIPS pipeline. It combines the main
// opcode decoder, the ALU-control decoder and the 32-bit ALU. The execute
// result and zero flag are registered once for the EX/MEM boundary.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (clears the registered outputs only)
//   op           instruction opcode, bits [31:26]
//   funct        function field, bits [5:0]
//   readdata1    register operand A
//   readdata2    register operand B
//   imm          sign-extended immediate
//   jump, regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch
//                combinational control word
//   aluop        combinational 2-bit ALU op code
//   aluctrl      combinational 4-bit ALU operation
//   aluresult    combinational ALU result
//   zero         combinational flag, 1 when aluresult is all zeros
//   aluresult_q  aluresult captured at the rising edge
//   zero_q       zero captured at the rising edge
// -----------------------------------------------------------------------------
module alu_ctrl_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic [31:0] readdata1,
    input  logic [31:0] readdata2,
    input  logic [31:0] imm,
    output logic        jump,
    output logic        regdst,
    output logic        alusrc,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        branch,
    output logic [1:0]  aluop,
    output logic [3:0]  aluctrl,
    output logic [31:0] aluresult,
    output logic        zero,
    output logic [31:0] aluresult_q,
    output logic        zero_q
);

    // Opcodes recognised by the main decoder.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes.
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    // ALU op codes from the main decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operations.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // -------------------------------------------------------------------------
    // Main decoder
    // -------------------------------------------------------------------------
    always_comb begin
        jump     = 1'b0;
        regdst   = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        branch   = 1'b0;
        aluop    = ALUOP_ADD;
        case (op)
            OP_RTYPE: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                aluop    = ALUOP_FUNCT;
            end
            OP_LW: begin
                alusrc   = 1'b1;
                memtoreg = 1'b1;
                regwrite = 1'b1;
                memread  = 1'b1;
            end
            OP_SW: begin
                alusrc   = 1'b1;
                memwrite = 1'b1;
            end
            OP_BEQ: begin
                branch   = 1'b1;
                aluop    = ALUOP_SUB;
            end
            OP_ADDI: begin
                alusrc   = 1'b1;
                regwrite = 1'b1;
            end
            OP_J: begin
                jump     = 1'b1;
            end
            default: begin
                // Unknown opcodes behave as a NOP: everything stays low.
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // ALU control
    // -------------------------------------------------------------------------
    always_comb begin
        aluctrl = ALU_ADD;
        case (aluop)
            ALUOP_SUB:   aluctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  aluctrl = ALU_ADD;
                    FN_SUB:  aluctrl = ALU_SUB;
                    FN_AND:  aluctrl = ALU_AND;
                    FN_OR:   aluctrl = ALU_OR;
                    FN_SLT:  aluctrl = ALU_SLT;
                    FN_NOR:  aluctrl = ALU_NOR;
                    default: aluctrl = ALU_ADD;
                endcase
            end
            default:     aluctrl = ALU_ADD;   // 00 and 11 both add
        endcase
    end

    // -------------------------------------------------------------------------
    // ALU datapath
    // -------------------------------------------------------------------------
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] and_bits;
    logic [31:0] or_bits;
    logic [31:0] nor_bits;
    logic [31:0] sum_val;
    logic [31:0] diff_val;
    logic        slt_bit;

    assign operand_a = readdata1;
    assign operand_b = alusrc ? imm : readdata2;

    // Bitwise lanes, one per bit.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_bit_lane
            assign and_bits[gi] = operand_a[gi] & operand_b[gi];
            assign or_bits[gi]  = operand_a[gi] | operand_b[gi];
            assign nor_bits[gi] = ~(operand_a[gi] | operand_b[gi]);
        end
    endgenerate

    // Wrap-around arithmetic; carries and overflow are simply dropped.
    assign sum_val  = operand_a + operand_b;
    assign diff_val = operand_a - operand_b;

    // Signed less-than: when the signs differ the negative operand is smaller,
    // otherwise the subtraction cannot overflow and its sign bit decides.
    assign slt_bit = (operand_a[31] ^ operand_b[31]) ? operand_a[31] : diff_val[31];

    always_comb begin
        aluresult = 32'd0;
        case (aluctrl)
            ALU_AND: aluresult = and_bits;
            ALU_OR:  aluresult = or_bits;
            ALU_ADD: aluresult = sum_val;
            ALU_SUB: aluresult = diff_val;
            ALU_SLT: aluresult = {31'd0, slt_bit};
            ALU_NOR: aluresult = nor_bits;
            default: aluresult = 32'd0;
        endcase
    end

    assign zero = ~|aluresult;

    // -------------------------------------------------------------------------
    // EX/MEM capture
    // -------------------------------------------------------------------------
    logic [31:0] aluresult_reg;
    logic        zero_reg;
    logic [31:0] aluresult_next;
    logic        zero_next;

    assign aluresult_next = aluresult;
    assign zero_next      = zero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aluresult_reg <= 32'd0;
            zero_reg      <= 1'b0;
        end else begin
            aluresult_reg <= aluresult_next;
            zero_reg      <= zero_next;
        end
    end

    assign aluresult_q = aluresult_reg;
    assign zero_q      = zero_reg;

endmodule

// File: tb/tb_alu_ctrl_unit.sv
module tb_alu_ctrl_unit;

    logic        clk;
    logic        rst_n;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] readdata1;
    logic [31:0] readdata2;
    logic [31:0] imm;
    logic        jump, regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0]  aluop;
    logic [3:0]  aluctrl;
    logic [31:0] aluresult;
    logic        zero;
    logic [31:0] aluresult_q;
    logic        zero_q;

    int checks = 0;
    int errors = 0;

    alu_ctrl_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct       (funct),
        .readdata1   (readdata1),
        .readdata2   (readdata2),
        .imm         (imm),
        .jump        (jump),
        .regdst      (regdst),
        .alusrc      (alusrc),
        .memtoreg    (memtoreg),
        .regwrite    (regwrite),
        .memread     (memread),
        .memwrite    (memwrite),
        .branch      (branch),
        .aluop       (aluop),
        .aluctrl     (aluctrl),
        .aluresult   (aluresult),
        .zero        (zero),
        .aluresult_q (aluresult_q),
        .zero_q      (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word packed as {jump,regdst,alusrc,memtoreg,regwrite,memread,memwrite,branch,aluop}
    logic [9:0] dut_cw;
    assign dut_cw = {jump, regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop};

    // ------------------------------------------------------------------
    // Reference model: table lookup for decode, plain arithmetic for ALU
    // ------------------------------------------------------------------
    function automatic void model(input logic [5:0] o, input logic [5:0] f,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] im,
                                  output logic [9:0] cw, output logic [3:0] ac,
                                  output logic [31:0] r);
        logic [31:0] bb;
        case (o)
            6'b000000: cw = 10'b0100100010;
            6'b100011: cw = 10'b0011110000;
            6'b101011: cw = 10'b0010001000;
            6'b000100: cw = 10'b0000000101;
            6'b001000: cw = 10'b0010100000;
            6'b000010: cw = 10'b1000000000;
            default:   cw = 10'b0000000000;
        endcase
        if (cw[1:0] == 2'b01)       ac = 4'b0110;
        else if (cw[1:0] != 2'b10)  ac = 4'b0010;
        else if (f == 6'b100010)    ac = 4'b0110;
        else if (f == 6'b100100)    ac = 4'b0000;
        else if (f == 6'b100101)    ac = 4'b0001;
        else if (f == 6'b101010)    ac = 4'b0111;
        else if (f == 6'b100111)    ac = 4'b1100;
        else                        ac = 4'b0010;
        bb = cw[7] ? im : b;
        case (ac)
            4'b0000: r = a & bb;
            4'b0001: r = a | bb;
            4'b0010: r = 32'(a + bb);
            4'b0110: r = 32'(a - bb);
            4'b0111: r = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
            4'b1100: r = ~(a | bb);
            default: r = 32'd0;
        endcase
    endfunction

    // Expected registered outputs, updated at every rising edge.
    logic [31:0] exp_q;
    logic        exp_zq;
    logic        exp_known = 1'b0;

    always @(posedge clk) begin
        logic [9:0]  cw;
        logic [3:0]  ac;
        logic [31:0] r;
        model(op, funct, readdata1, readdata2, imm, cw, ac, r);
        if (!rst_n) begin
            exp_q  <= 32'd0;
            exp_zq <= 1'b0;
        end else begin
            exp_q  <= r;
            exp_zq <= (r == 32'd0);
        end
        exp_known <= 1'b1;
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        logic [9:0]  cw;
        logic [3:0]  ac;
        logic [31:0] r;
        model(op, funct, readdata1, readdata2, imm, cw, ac, r);
        checks++;
        if (dut_cw !== cw) begin
            errors++;
            $display("FAIL model_ctrl op=%b got %b want %b", op, dut_cw, cw);
        end
        checks++;
        if (aluctrl !== ac) begin
            errors++;
            $display("FAIL model_aluctrl op=%b funct=%b got %b want %b", op, funct, aluctrl, ac);
        end
        checks++;
        if (aluresult !== r || zero !== (r == 32'd0)) begin
            errors++;
            $display("FAIL model_result op=%b funct=%b got %h/%b want %h/%b",
                     op, funct, aluresult, zero, r, (r == 32'd0));
        end
        if (exp_known) begin
            checks++;
            if (aluresult_q !== exp_q || zero_q !== exp_zq) begin
                errors++;
                $display("FAIL model_q got %h/%b want %h/%b", aluresult_q, zero_q, exp_q, exp_zq);
            end
        end
    end

    // Literal expectations that pin the model.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Apply an operation just after a rising edge and settle to the next
    // falling edge (plus a little) so the combinational outputs can be read.
    task automatic drive(input logic [5:0] o, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        @(posedge clk);
        #1;
        op = o; funct = f; readdata1 = a; readdata2 = b; imm = im;
        @(negedge clk);
        #1;
        $display("op=%b funct=%b a=%h b=%h imm=%h -> ctrl=%b aluctrl=%b res=%h zero=%b q=%h zq=%b",
                 op, funct, readdata1, readdata2, imm, dut_cw, aluctrl, aluresult, zero,
                 aluresult_q, zero_q);
    endtask

    initial begin
        rst_n = 1'b0;
        op = 6'd0; funct = 6'd0; readdata1 = 32'd0; readdata2 = 32'd0; imm = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", aluresult_q, 32'd0);
        chk("reset_zq", {31'd0, zero_q}, 32'd0);
        rst_n = 1'b1;

        // R-type add
        drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
        chk("radd_regdst", {31'd0, regdst}, 32'd1);
        chk("radd_regwrite", {31'd0, regwrite}, 32'd1);
        chk("radd_aluctrl", {28'd0, aluctrl}, 32'd2);
        chk("radd_result", aluresult, 32'd12);
        chk("radd_zero", {31'd0, zero}, 32'd0);

        // beq equal operands
        drive(6'b000100, 6'b000000, 32'h1234, 32'h1234, 32'd0);
        chk("radd_q", aluresult_q, 32'd12);
        chk("beq_branch", {31'd0, branch}, 32'd1);
        chk("beq_aluctrl", {28'd0, aluctrl}, 32'h6);
        chk("beq_result", aluresult, 32'd0);
        chk("beq_zero", {31'd0, zero}, 32'd1);

        // R-type sub underflow
        drive(6'b000000, 6'b100010, 32'd0, 32'd1, 32'd0);
        chk("beq_zq", {31'd0, zero_q}, 32'd1);
        chk("sub_result", aluresult, 32'hFFFFFFFF);

        drive(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'd0);
        chk("slt_result", aluresult, 32'd1);
        drive(6'b000000, 6'b100111, 32'd0, 32'd0, 32'd0);
        chk("nor_result", aluresult, 32'hFFFFFFFF);
        drive(6'b000000, 6'b100000, 32'h7FFFFFFF, 32'd1, 32'd0);
        chk("ovf_result", aluresult, 32'h80000000);
        drive(6'b000000, 6'b100100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
        chk("and_result", aluresult, 32'hF000_F000);
        drive(6'b000000, 6'b100101, 32'hF0F0_F0F0, 32'h0F00_0000, 32'd0);
        chk("or_result", aluresult, 32'hFFF0_F0F0);

        // lw / sw / addi
        drive(6'b100011, 6'b000000, 32'h100, 32'hDEAD_BEEF, 32'hFFFFFFFC);
        chk("lw_ctrl", {22'd0, dut_cw}, {22'd0, 10'b0011110000});
        chk("lw_result", aluresult, 32'h000000FC);
        drive(6'b101011, 6'b000000, 32'h100, 32'd0, 32'd8);
        chk("sw_memwrite", {31'd0, memwrite}, 32'd1);
        chk("sw_regwrite", {31'd0, regwrite}, 32'd0);
        drive(6'b001000, 6'b000000, 32'd10, 32'd99, 32'hFFFFFFFF);
        chk("addi_result", aluresult, 32'd9);

        // jump and illegal
        drive(6'b000010, 6'b000000, 32'd1, 32'd2, 32'd3);
        chk("j_ctrl", {22'd0, dut_cw}, {22'd0, 10'b1000000000});
        drive(6'b111111, 6'b100010, 32'd1, 32'd2, 32'd3);
        chk("illegal_ctrl", {22'd0, dut_cw}, 32'd0);
        chk("illegal_aluctrl", {28'd0, aluctrl}, 32'h2);
        drive(6'b000000, 6'b000000, 32'd1, 32'd2, 32'd0);
        chk("funct0_aluctrl", {28'd0, aluctrl}, 32'h2);

        // Reset mid-stream
        drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
        drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
        chk("pre_reset_q", aluresult_q, 32'd12);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_q", aluresult_q, 32'd0);
        chk("rst_zq", {31'd0, zero_q}, 32'd0);
        chk("rst_comb_result", aluresult, 32'd12);
        rst_n = 1'b1;
        readdata1 = 32'd1; readdata2 = 32'd2;
        @(posedge clk);
        #1;
        chk("release_q", aluresult_q, 32'd3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [5:0] ops [7];
            logic [5:0] fns [7];
            ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
            fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b000000};
            @(posedge clk);
            #1;
            rst_n     = ($urandom_range(0, 19) != 0);
            op        = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            funct     = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
            readdata1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
            readdata2 = ($urandom_range(0, 3) == 0) ? readdata1 : $urandom;
            imm       = ($urandom_range(0, 3) == 0) ? readdata1 : $urandom;
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
